// File: rtl/cacheline_arbiter.sv
// Round-robin arbiter for the shared cacheline memory port.
// One 256-bit line transfer at a time; I-cache and D-cache miss paths compete.
module cacheline_arbiter #(
    parameter int LINE_BITS = 256,
    parameter int ADDR_BITS = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_read,
    input  logic [ADDR_BITS-1:0] i_address,
    output logic [LINE_BITS-1:0] i_rdata,
    output logic                 i_resp,
    input  logic                 d_read,
    input  logic                 d_write,
    input  logic [ADDR_BITS-1:0] d_address,
    input  logic [LINE_BITS-1:0] d_wdata,
    output logic [LINE_BITS-1:0] d_rdata,
    output logic                 d_resp,
    output logic                 pmem_read,
    output logic                 pmem_write,
    output logic [ADDR_BITS-1:0] pmem_address,
    output logic [LINE_BITS-1:0] pmem_wdata,
    input  logic [LINE_BITS-1:0] pmem_rdata,
    input  logic                 pmem_resp
);

    typedef enum logic [2:0] {
        IDLE,
        SERVE_I,
        SERVE_D,
        RESP_I,
        RESP_D
    } state_t;

    state_t               state;
    logic                 last_d;
    logic [LINE_BITS-1:0] line;
    logic                 i_pend;
    logic                 d_pend;
    logic                 grant_i;
    logic                 grant_d;

    // On a tie the side that did not win last time gets the port.
    always_comb begin
        i_pend  = i_read;
        d_pend  = d_read | d_write;
        grant_i = i_pend && (!d_pend || last_d);
        grant_d = d_pend && !grant_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            last_d       <= 1'b0;
            line         <= '0;
            i_resp       <= 1'b0;
            d_resp       <= 1'b0;
            pmem_read    <= 1'b0;
            pmem_write   <= 1'b0;
            pmem_address <= '0;
            pmem_wdata   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    unique case (1'b1)
                        grant_i: begin
                            state        <= SERVE_I;
                            last_d       <= 1'b0;
                            pmem_read    <= 1'b1;
                            pmem_address <= i_address;
                        end
                        grant_d: begin
                            state        <= SERVE_D;
                            last_d       <= 1'b1;
                            pmem_address <= d_address;
                            // A combined read+write request is a writeback.
                            if (d_write) begin
                                pmem_write <= 1'b1;
                                pmem_wdata <= d_wdata;
                            end else begin
                                pmem_read  <= 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
                SERVE_I: begin
                    if (pmem_resp) begin
                        line      <= pmem_rdata;
                        pmem_read <= 1'b0;
                        i_resp    <= 1'b1;
                        state     <= RESP_I;
                    end
                end
                SERVE_D: begin
                    if (pmem_resp) begin
                        if (pmem_read) begin
                            line <= pmem_rdata;
                        end
                        pmem_read  <= 1'b0;
                        pmem_write <= 1'b0;
                        d_resp     <= 1'b1;
                        state      <= RESP_D;
                    end
                end
                RESP_I: begin
                    i_resp <= 1'b0;
                    state  <= IDLE;
                end
                RESP_D: begin
                    d_resp <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign i_rdata = line;
    assign d_rdata = line;

endmodule

// File: tb/tb_cacheline_arbiter.sv
// Directed bench for cacheline_arbiter.
// Drives requests and memory responses cycle by cycle against fixed expectations.
module tb_cacheline_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic         i_read;
    logic [31:0]  i_address;
    logic [255:0] i_rdata;
    logic         i_resp;
    logic         d_read;
    logic         d_write;
    logic [31:0]  d_address;
    logic [255:0] d_wdata;
    logic [255:0] d_rdata;
    logic         d_resp;
    logic         pmem_read;
    logic         pmem_write;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_wdata;
    logic [255:0] pmem_rdata;
    logic         pmem_resp;

    int checks = 0;
    int errors = 0;

    logic [255:0] line_a5;
    logic [255:0] line_12;
    logic [255:0] line_3c;
    logic [255:0] line_77;
    logic [255:0] line_junk;
    logic [255:0] last_line;

    cacheline_arbiter #(
        .LINE_BITS(256),
        .ADDR_BITS(32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_read      (i_read),
        .i_address   (i_address),
        .i_rdata     (i_rdata),
        .i_resp      (i_resp),
        .d_read      (d_read),
        .d_write     (d_write),
        .d_address   (d_address),
        .d_wdata     (d_wdata),
        .d_rdata     (d_rdata),
        .d_resp      (d_resp),
        .pmem_read   (pmem_read),
        .pmem_write  (pmem_write),
        .pmem_address(pmem_address),
        .pmem_wdata  (pmem_wdata),
        .pmem_rdata  (pmem_rdata),
        .pmem_resp   (pmem_resp)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] got,
                         input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, ".pmem_read"}, 256'(pmem_read), 256'(1'b0));
        check({tag, ".pmem_write"}, 256'(pmem_write), 256'(1'b0));
        check({tag, ".i_resp"}, 256'(i_resp), 256'(1'b0));
        check({tag, ".d_resp"}, 256'(d_resp), 256'(1'b0));
    endtask

    // Entered in the IDLE cycle where the request is visible (cycle 0);
    // returns in the IDLE cycle following the response (cycle n+2).
    task automatic xfer(input string tag, input bit is_i, input bit is_wr,
                        input logic [31:0] addr, input logic [255:0] wdata,
                        input int lat, input logic [255:0] rd,
                        input bit drop);
        tick();
        for (int c = 1; c <= lat; c++) begin
            check({tag, ".rd_cmd"}, 256'(pmem_read), 256'(!is_wr));
            check({tag, ".wr_cmd"}, 256'(pmem_write), 256'(is_wr));
            check({tag, ".addr"}, 256'(pmem_address), 256'(addr));
            if (is_wr) begin
                check({tag, ".wdata"}, pmem_wdata, wdata);
                d_wdata = ~d_wdata;
            end
            check({tag, ".i_resp_early"}, 256'(i_resp), 256'(1'b0));
            check({tag, ".d_resp_early"}, 256'(d_resp), 256'(1'b0));
            if (drop && c == 1) begin
                i_read  = 1'b0;
                d_read  = 1'b0;
                d_write = 1'b0;
            end
            if (c == lat) begin
                pmem_resp  = 1'b1;
                pmem_rdata = rd;
            end
            tick();
        end
        pmem_resp  = 1'b0;
        pmem_rdata = line_junk;
        check({tag, ".i_resp"}, 256'(i_resp), 256'(is_i));
        check({tag, ".d_resp"}, 256'(d_resp), 256'(!is_i));
        check({tag, ".rd_off"}, 256'(pmem_read), 256'(1'b0));
        check({tag, ".wr_off"}, 256'(pmem_write), 256'(1'b0));
        if (!is_wr) last_line = rd;
        check({tag, ".i_rdata"}, i_rdata, last_line);
        check({tag, ".d_rdata"}, d_rdata, last_line);
        if (is_i) begin
            i_read = 1'b0;
        end else begin
            d_read  = 1'b0;
            d_write = 1'b0;
        end
        tick();
        check_quiet({tag, ".after"});
    endtask

    initial begin
        line_a5   = {32{8'hA5}};
        line_12   = {16{16'h1234}};
        line_3c   = {32{8'h3C}};
        line_77   = {32{8'h77}};
        line_junk = {32{8'hEE}};
        last_line = '0;

        rst        = 1'b1;
        i_read     = 1'b0;
        i_address  = '0;
        d_read     = 1'b0;
        d_write    = 1'b0;
        d_address  = '0;
        d_wdata    = '0;
        pmem_rdata = line_junk;
        pmem_resp  = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check_quiet("reset");
        check("reset.addr", 256'(pmem_address), 256'(32'h0));
        check("reset.wdata", pmem_wdata, 256'(0));
        check("reset.rdata", i_rdata, 256'(0));

        // Single I read, memory latency 5.
        i_read    = 1'b1;
        i_address = 32'h0000_1000;
        xfer("i_single", 1'b1, 1'b0, 32'h0000_1000, '0, 5, line_a5, 1'b0);

        // Tie after reset: D, then I at n+3, then D again.
        i_read    = 1'b1;
        i_address = 32'h0000_3000;
        d_read    = 1'b1;
        d_address = 32'h0000_4000;
        xfer("tie1_d", 1'b0, 1'b0, 32'h0000_4000, '0, 3, line_3c, 1'b0);
        xfer("tie1_i", 1'b1, 1'b0, 32'h0000_3000, '0, 2, line_77, 1'b0);
        i_read    = 1'b1;
        i_address = 32'h0000_5000;
        d_read    = 1'b1;
        d_address = 32'h0000_6000;
        xfer("tie2_d", 1'b0, 1'b0, 32'h0000_6000, '0, 1, line_a5, 1'b0);
        xfer("tie2_i", 1'b1, 1'b0, 32'h0000_5000, '0, 4, line_3c, 1'b0);

        // Writeback; d_wdata toggles during service, rdata untouched.
        d_write   = 1'b1;
        d_address = 32'h0000_2040;
        d_wdata   = line_12;
        xfer("wb", 1'b0, 1'b1, 32'h0000_2040, line_12, 4, line_junk, 1'b0);
        check("wb.rdata_kept", d_rdata, line_3c);

        // Read and write together go out as a write only.
        d_read    = 1'b1;
        d_write   = 1'b1;
        d_address = 32'h0000_7080;
        d_wdata   = line_77;
        xfer("rw", 1'b0, 1'b1, 32'h0000_7080, line_77, 3, line_junk, 1'b0);

        // Requester drops mid-service; transfer still completes.
        i_read    = 1'b1;
        i_address = 32'h0000_8000;
        xfer("drop", 1'b1, 1'b0, 32'h0000_8000, '0, 4, line_12, 1'b1);

        // Spurious memory response in IDLE.
        pmem_resp  = 1'b1;
        pmem_rdata = line_junk;
        tick();
        pmem_resp = 1'b0;
        check_quiet("spur1");
        check("spur1.rdata", i_rdata, line_12);
        tick();
        check_quiet("spur2");
        check("spur2.rdata", d_rdata, line_12);

        // Reset during SERVE_D aborts silently and clears last_grant.
        d_write   = 1'b1;
        d_address = 32'h0000_9000;
        d_wdata   = line_a5;
        tick();
        tick();
        check("abort.wr_cmd", 256'(pmem_write), 256'(1'b1));
        rst = 1'b1;
        tick();
        rst     = 1'b0;
        d_write = 1'b0;
        check_quiet("abort");
        check("abort.addr", 256'(pmem_address), 256'(32'h0));
        check("abort.wdata", pmem_wdata, 256'(0));
        check("abort.rdata", i_rdata, 256'(0));
        last_line = '0;
        tick();
        check_quiet("abort.idle");

        i_read    = 1'b1;
        i_address = 32'h0000_A000;
        d_read    = 1'b1;
        d_address = 32'h0000_B000;
        xfer("tie3_d", 1'b0, 1'b0, 32'h0000_B000, '0, 2, line_77, 1'b0);
        xfer("tie3_i", 1'b1, 1'b0, 32'h0000_A000, '0, 2, line_a5, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
